// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and write/overflow/underflow strobes.
// Occupancy flags decode combinationally from the occupancy counter.
module sync_fifo #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [FIFO_WIDTH-1:0]         data_in,
  input  logic                          wr_en,
  input  logic                          rd_en,
  output logic [FIFO_WIDTH-1:0]         data_out,
  output logic                          wr_ack,
  output logic                          overflow,
  output logic                          underflow,
  output logic                          full,
  output logic                          empty,
  output logic                          almostfull,
  output logic                          almostempty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full        = (count == CW'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign almostfull  = (count == CW'(FIFO_DEPTH - 1));
  assign almostempty = (count == CW'(1));

  // Acceptance uses the flags as they stand before the edge.
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  // Storage has no reset; stale words are unreachable once count clears.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_ok;
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + AW'(1);
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed-vector bench for sync_fifo.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_sync_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_in = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] data_out;
  logic        wr_ack, overflow, underflow;
  logic        full, empty, almostfull, almostempty;
  logic [3:0]  count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_fifo #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in),
    .wr_en(wr_en), .rd_en(rd_en), .data_out(data_out),
    .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
    .full(full), .empty(empty), .almostfull(almostfull),
    .almostempty(almostempty), .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_af", 32'(almostfull), 0);
    chk("rst_ae", 32'(almostempty), 0);
    chk("rst_count", 32'(count), 0);
    #20 rst_n = 1'b1;
    step();

    rd_en = 1'b1;
    step();
    chk("uf0", 32'(underflow), 1);
    chk("uf0_dout", 32'(data_out), 0);
    chk("uf0_empty", 32'(empty), 1);
    chk("uf0_count", 32'(count), 0);
    rd_en = 1'b0;

    wr_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      data_in = 16'(i);
      step();
      chk("fill_ack", 32'(wr_ack), 1);
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_af", 32'(almostfull), (i == 7) ? 1 : 0);
      chk("fill_full", 32'(full), (i == 8) ? 1 : 0);
    end
    data_in = 16'hFFFF;
    step();
    chk("ovf", 32'(overflow), 1);
    chk("ovf_ack", 32'(wr_ack), 0);
    chk("ovf_count", 32'(count), 8);
    wr_en = 1'b0;

    rd_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("drain_data", 32'(data_out), 32'(i));
      chk("drain_count", 32'(count), 32'(8 - i));
      chk("drain_ae", 32'(almostempty), (i == 7) ? 1 : 0);
      chk("drain_empty", 32'(empty), (i == 8) ? 1 : 0);
    end
    step();
    chk("uf1", 32'(underflow), 1);
    chk("uf1_hold", 32'(data_out), 32'h0008);
    rd_en = 1'b0;
    step();
    chk("uf_clr", 32'(underflow), 0);
    chk("ovf_clr", 32'(overflow), 0);

    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 16'h0100 + 16'(i);
      step();
    end
    chk("pre_stream_count", 32'(count), 4);
    rd_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      data_in = 16'h0104 + 16'(k);
      step();
      chk("stream_count", 32'(count), 4);
      chk("stream_ack", 32'(wr_ack), 1);
      chk("stream_data", 32'(data_out), 32'h0100 + 32'(k));
    end
    wr_en = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      chk("stream_tail", 32'(data_out), 32'h0114 + 32'(j));
    end
    chk("stream_empty", 32'(empty), 1);
    rd_en = 1'b0;

    wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in = 16'h0200 + 16'(i);
      step();
    end
    chk("full2", 32'(full), 1);
    rd_en = 1'b1;
    data_in = 16'hAAAA;
    step();
    chk("fullrw_count", 32'(count), 7);
    chk("fullrw_ovf", 32'(overflow), 1);
    chk("fullrw_ack", 32'(wr_ack), 0);
    chk("fullrw_data", 32'(data_out), 32'h0200);
    wr_en = 1'b0;
    for (int i = 1; i < 8; i++) begin
      step();
      chk("fullrw_drain", 32'(data_out), 32'h0200 + 32'(i));
    end
    chk("empty2", 32'(empty), 1);
    wr_en = 1'b1;
    data_in = 16'h5555;
    step();
    chk("emptyrw_count", 32'(count), 1);
    chk("emptyrw_uf", 32'(underflow), 1);
    chk("emptyrw_ack", 32'(wr_ack), 1);
    chk("emptyrw_hold", 32'(data_out), 32'h0207);
    wr_en = 1'b0;
    step();
    chk("emptyrw_data", 32'(data_out), 32'h5555);
    chk("emptyrw_count2", 32'(count), 0);
    rd_en = 1'b0;

    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = 16'h0300 + 16'(i);
      step();
    end
    wr_en = 1'b0;
    chk("pre_rst_count", 32'(count), 5);
    chk("pre_rst_ack", 32'(wr_ack), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_ack", 32'(wr_ack), 0);
    chk("arst_ovf", 32'(overflow), 0);
    chk("arst_uf", 32'(underflow), 0);
    chk("arst_dout", 32'(data_out), 0);
    #2 rst_n = 1'b1;
    rd_en = 1'b1;
    step();
    chk("post_rst_uf", 32'(underflow), 1);
    chk("post_rst_empty", 32'(empty), 1);
    chk("post_rst_dout", 32'(data_out), 0);
    rd_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have parameter FIFO_WIDTH, default 16, meaning data word width in bits.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, meaning number of storage entries; power of two, >= 4.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port data_in  input  FIFO_WIDTH  write data.
REQ-006 The block SHALL have port wr_en  input  1  write request.
REQ-007 The block SHALL have port rd_en  input  1  read request.
REQ-008 The block SHALL have port data_out  output  FIFO_WIDTH  registered read data.
REQ-009 The block SHALL have port wr_ack  output  1  registered; previous-cycle write accepted.
REQ-010 The block SHALL have port overflow  output  1  registered; previous-cycle write rejected because full.
REQ-011 The block SHALL have port underflow  output  1  registered; previous-cycle read rejected because empty.
REQ-012 The block SHALL have ports full, empty, almostfull, almostempty  output  1 each  combinational occupancy flags.
REQ-013 The block SHALL have port count  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Function
REQ-014 Write accepted when wr_en=1 and full=0: data_in stored at wr_ptr, wr_ptr increments, wr_ack=1 on next cycle.
REQ-015 Write with wr_en=1 and full=1 SHALL be dropped: memory/wr_ptr unchanged, overflow=1 and wr_ack=0 next cycle.
REQ-016 With wr_en=0, wr_ack and overflow SHALL be 0 next cycle.
REQ-017 Read accepted when rd_en=1 and empty=0: data_out <= mem[rd_ptr], rd_ptr increments; data visible 1 cycle after request.
REQ-018 Read with rd_en=1 and empty=1 SHALL be rejected: rd_ptr and data_out hold, underflow=1 next cycle; rd_en=0 gives underflow=0.
REQ-019 Acceptance SHALL be judged on pre-edge flags: when full, simultaneous wr_en+rd_en performs read only (overflow=1); when empty, simultaneous wr_en+rd_en performs write only (underflow=1).
REQ-020 count SHALL +1 on accepted write only, -1 on accepted read only, unchanged when both or neither accepted; never exceeds FIFO_DEPTH or goes below 0.
REQ-021 Pointers SHALL be $clog2(FIFO_DEPTH) bits and wrap FIFO_DEPTH-1 -> 0 with no gap.
REQ-022 Flags SHALL decode from count: full = (count==FIFO_DEPTH); empty = (count==0); almostfull = (count==FIFO_DEPTH-1); almostempty = (count==1).
REQ-023 Data SHALL leave in exact write order; no word lost or duplicated across any number of wraps.

Reset
REQ-024 rst_n=0 SHALL immediately, independent of clk, clear wr_ptr, rd_ptr, count, data_out, wr_ack, overflow, underflow to 0.
REQ-025 During/after reset flags SHALL read empty=1, full=0, almostfull=0, almostempty=0; storage array need not be cleared.
REQ-026 Reset asserted mid-operation SHALL discard all stored words; first read after release with no writes underflows.

Verification
REQ-027 Reset, then rd_en=1 one cycle -> underflow=1, data_out=0, empty=1, count=0.
REQ-028 Write 0x0001..0x0008 (8 cycles) -> wr_ack=1 each, almostfull after 7th, full=1 and count=8 after 8th; 9th write 0xFFFF -> overflow=1, wr_ack=0, count=8.
REQ-029 Then read 8 cycles -> data_out 0x0001..0x0008 in order, almostempty at count=1, empty=1 after 8th; 9th read -> underflow=1, data_out holds 0x0008.
REQ-030 count=4, wr_en=rd_en=1 for 20 cycles with incrementing data -> count stays 4, wr_ack=1 every cycle, output order preserved across pointer wrap.
REQ-031 full, wr_en=rd_en=1 -> read only, count=7, overflow=1; empty, wr_en=rd_en=1 -> write only, count=1, underflow=1.
REQ-032 count=5, assert rst_n=0 between clock edges -> count=0, empty=1, wr_ack/overflow/underflow=0 before next edge.
